// File: rtl/rs_bm_channel_arbiter.sv
// Round-robin arbiter sharing one serial BM engine between NCH syndrome producers,
// with a tag FIFO naming the channel of each codeword in flight. Optional macro: RS_BM_ARB_STATS_EN.
module rs_bm_channel_arbiter #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned SYNDW    = 256,
  parameter int unsigned TAGDEPTH = 4,
  parameter int unsigned CHW      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req_valid,
  input  logic [NCH-1:0]       req_sop,
  input  logic [NCH-1:0]       req_eop,
  input  logic [NCH*SYNDW-1:0] req_synd,
  output logic [NCH-1:0]       req_ready,
  output logic                 syn_valid,
  output logic                 syn_sop,
  output logic                 syn_eop,
  output logic [SYNDW-1:0]     syn_synd,
  input  logic                 syn_ready,
  input  logic                 bm_valid,
  input  logic                 bm_ready,
  input  logic                 bm_eop,
  output logic [CHW-1:0]       tag_chan,
  output logic                 tag_valid,
  output logic                 proto_err
`ifdef RS_BM_ARB_STATS_EN
  ,
  output logic [NCH*16-1:0]    stat_cw_count
`endif
);

  localparam int unsigned AW = (TAGDEPTH > 1) ? $clog2(TAGDEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t         state_q, state_d;
  logic [CHW-1:0] grant_q, grant_d;
  logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
  logic           first_q, first_d;

  logic [NCH-1:0] cand;
  logic           found;
  logic [CHW-1:0] pick;
  int unsigned    idx;

  logic           hs;
  logic           push;
  logic           cw_done;

  logic [CHW-1:0] tag_mem [TAGDEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           fifo_empty, fifo_full;
  logic           pop_req, pop_ok, push_ok;

  logic [SYNDW-1:0] synd_arr [NCH];

  // Unpack the flat syndrome bus into per-channel words
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      synd_arr[i] = req_synd[i*SYNDW +: SYNDW];
    end
  end

  // Round-robin search starting just after the last served channel
  assign cand = req_valid & req_sop;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && cand[CHW'(idx)]) begin
        found = 1'b1;
        pick  = CHW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= CHW'(NCH - 1);
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      first_q  <= first_d;
    end
  end

  // Next state and the combinational BM-side mux; only the first accepted beat pushes a tag
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    first_d   = first_q;
    req_ready = '0;
    syn_valid = 1'b0;
    syn_sop   = 1'b0;
    syn_eop   = 1'b0;
    syn_synd  = '0;
    hs        = 1'b0;
    push      = 1'b0;
    cw_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !fifo_full) begin
          grant_d = pick;
          first_d = 1'b1;
          state_d = LOCK;
        end
      end
      LOCK: begin
        syn_valid          = req_valid[grant_q];
        syn_sop            = req_sop[grant_q];
        syn_eop            = req_eop[grant_q];
        syn_synd           = synd_arr[grant_q];
        req_ready[grant_q] = syn_ready;
        hs                 = req_valid[grant_q] & syn_ready;
        push               = hs & req_sop[grant_q] & first_q;
        cw_done            = hs & req_eop[grant_q];
        if (hs) first_d = 1'b0;
        if (cw_done) begin
          rr_ptr_d = grant_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop_req    = bm_valid & bm_ready & bm_eop;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(TAGDEPTH));
  assign pop_ok     = pop_req & ~fifo_empty;
  assign push_ok    = push & (~fifo_full | pop_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (pop_req && fifo_empty) proto_err <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push_ok) tag_mem[wr_ptr_q] <= grant_q;
  end

  assign tag_valid = ~fifo_empty;
  assign tag_chan  = fifo_empty ? '0 : tag_mem[rd_ptr_q];

`ifdef RS_BM_ARB_STATS_EN
  logic [15:0] cw_cnt_q [NCH];

  // Completed-codeword counters, wrapping naturally at 16 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) cw_cnt_q[i] <= '0;
    end else if (cw_done) begin
      cw_cnt_q[grant_q] <= cw_cnt_q[grant_q] + 16'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      stat_cw_count[i*16 +: 16] = cw_cnt_q[i];
    end
  end
`endif

endmodule

// File: doc/rs_bm_channel_arbiter.md
Name: rs_bm_channel_arbiter

Overview:
Shares one serial Berlekamp-Massey engine (syn_in_* / bm_out_* interface of the RS decoder) between NCH syndrome producers.
- Round-robin grant per codeword; sop..eop held atomic.
- Records the granted channel in a tag FIFO. The downstream Chien/Forney demux reads which channel each BM result belongs to.
- Sits between the per-channel syndrome calculators and the BM stage.

Parameters:
NCH, 2, number of requesting syndrome channels (2..8)
SYNDW, 256, syndrome bus width (CHECK*BITSPERSYMBOL)
TAGDEPTH, 4, tag FIFO depth (power of 2, >=2); bounds codewords in flight inside BM
CHW, 1, channel-id width, must equal max(1, clog2(NCH))

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous active-low reset (0 = reset)
req_valid  in  NCH  per-channel beat valid
req_sop  in  NCH  per-channel start of codeword
req_eop  in  NCH  per-channel end of codeword
req_synd  in  NCH*SYNDW  per-channel syndromes; channel i at [i*SYNDW +: SYNDW]
req_ready  out  NCH  per-channel accept
syn_valid  out  1  to BM syn_in_valid
syn_sop  out  1  to BM syn_in_sop
syn_eop  out  1  to BM syn_in_eop
syn_synd  out  SYNDW  to BM syn_in_synd
syn_ready  in  1  from BM syn_in_ready
bm_valid  in  1  monitor of BM bm_out_valid
bm_ready  in  1  monitor of bm_out_ready
bm_eop  in  1  monitor of bm_out_eop
tag_chan  out  CHW  channel id of the oldest codeword in BM
tag_valid  out  1  tag FIFO non-empty
proto_err  out  1  sticky: tag pop on empty FIFO

Behaviour:
- Reset (rst=0, async): state=IDLE, grant=0, rr_ptr=NCH-1 (channel 0 first), FIFO empty, proto_err=0. Outputs: req_ready=0, syn_valid=0, syn_sop=0, syn_eop=0, syn_synd=0, tag_valid=0, tag_chan=0.
- FSM states: IDLE, LOCK.
- IDLE:
  - Candidates are channels with req_valid & req_sop.
  - If any candidate exists and the FIFO is not full, pick the first candidate searching rr_ptr+1, rr_ptr+2, ... modulo NCH. Register it as grant and go to LOCK.
  - req_ready=0 and syn_valid=0 in IDLE. This gives a one-cycle grant bubble.
  - A non-sop beat presented in IDLE is not accepted; it waits.
- LOCK, all combinational from grant:
  - syn_valid=req_valid[grant]; syn_sop, syn_eop and syn_synd are muxed from channel grant.
  - req_ready[grant]=syn_ready; all other req_ready bits are 0.
  - Handshake = syn_valid & syn_ready.
  - On a handshake with sop: push grant into the tag FIFO.
  - On a handshake with eop: rr_ptr<=grant, go to IDLE.
  - A beat with sop&eop does both and lasts one cycle.
  - A sop beat inside LOCK after the first beat is forwarded unchanged and causes no second push.
- Latency: request at cycle 0 in IDLE gives syn_valid at cycle 1. Minimum per-codeword throughput is beats+1 cycles.
- Tag FIFO:
  - Pop when bm_valid & bm_ready & bm_eop.
  - tag_chan/tag_valid reflect the head; a push into an empty FIFO is visible the next cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop on empty: ignored, proto_err<=1 (cleared only by reset).
  - A full FIFO blocks new grants only; a codeword already in LOCK completes.
  - Pointers wrap modulo TAGDEPTH; count width is clog2(TAGDEPTH)+1.
- The arbiter never drops or reorders beats within a codeword. Tags leave in grant order; BM is in-order.
- Reset asserted mid-LOCK aborts the codeword: the BM side sees syn_valid fall immediately. The system flushes BM via its own rst.

Optional Feature:
Macro RS_BM_ARB_STATS_EN.
- Defined: adds output stat_cw_count (NCH*16 bits). Per-channel 16-bit counters increment on each accepted eop beat of that channel, wrap at 0xFFFF->0, and reset to 0.
- Not defined: the port and counters are absent, and the rest of the behaviour is identical.

Test Plan:
- Single channel 0, one beat sop=eop=1, synd=0x..01, syn_ready=1 -> syn_valid at cycle 1 with synd 0x..01; tag_chan=0 and tag_valid=1 at cycle 2.
- Channels 0 and 1 both request continuously, 1-beat codewords -> grant order 0,1,0,1; tag FIFO contents 0,1,0,1.
- Channel 1 3-beat codeword with syn_ready low in beat 2 for 2 cycles, channel 0 requesting meanwhile -> channel 0 req_ready stays 0 until channel 1 eop; beats are forwarded in order.
- TAGDEPTH=4, no bm pops, 5 codewords queued -> 4 granted; 5th held with syn_valid=0; one bm eop pop -> 5th granted the next cycle.
- bm_valid&bm_ready&bm_eop with FIFO empty -> proto_err=1 and stays 1; tag_valid stays 0.
- rst=0 asserted mid-LOCK on beat 2 -> syn_valid=0 and tag_valid=0 immediately; after release, channel 0 wins first.
